// File: rtl/maxpool_2x2.sv
// maxpool_2x2: streaming 2x2 / stride-2 max-pool over a raster-ordered
// feature map of IMG_SIZE x IMG_SIZE pixels, CH signed 16-bit channels each.
// Even columns are parked in a hold register. Odd columns form a pair-max,
// which even rows store in a half-width line buffer and odd rows combine
// with the stored value to produce one pooled pixel.
// Optional feature macro: MAXPOOL_RELU_EN clamps negative pooled channels
// to zero ahead of the output register, so latency does not change.
module maxpool_2x2 #(
    parameter int IMG_SIZE = 32,
    parameter int CH       = 64
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 vld_in,
    input  logic [CH-1:0][15:0]  in,
    output logic                 vld_out,
    output logic [CH-1:0][15:0]  out
);

    localparam int CW       = (IMG_SIZE > 2) ? $clog2(IMG_SIZE) : 1;
    localparam int LB_DEPTH = IMG_SIZE / 2;
    localparam int LW       = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_SIZE - 1);
    localparam logic [CW-1:0] ROW_LAST = CW'(IMG_SIZE - 1);

    // Signed 16-bit maximum; on a tie either operand is the same value.
    function automatic logic [15:0] smax16(input logic [15:0] a, input logic [15:0] b);
        if ($signed(a) > $signed(b)) begin
            return a;
        end else begin
            return b;
        end
    endfunction

`ifdef MAXPOOL_RELU_EN
    // Clamp a signed 16-bit value to zero when negative.
    function automatic logic [15:0] relu16(input logic [15:0] a);
        if (a[15]) begin
            return 16'h0000;
        end else begin
            return a;
        end
    endfunction
`endif

    logic [CW-1:0]         col_r;
    logic [CW-1:0]         row_r;
    logic [CH-1:0][15:0]   hold_r;
    logic [CH-1:0][15:0]   linebuf_r [LB_DEPTH];
    logic                  vld_out_r;
    logic [CH-1:0][15:0]   out_r;

    logic [LW-1:0]         lb_addr_s;
    logic [CH-1:0][15:0]   pm_s;
    logic [CH-1:0][15:0]   pool_s;
    logic                  emit_s;
    logic                  lb_wr_s;
    logic                  hold_wr_s;

    // Decode the current raster position into line-buffer address and write/emit strobes.
    always_comb begin
        lb_addr_s = LW'(col_r >> 1);
        hold_wr_s = vld_in & ~col_r[0];
        lb_wr_s   = vld_in &  col_r[0] & ~row_r[0];
        emit_s    = vld_in &  col_r[0] &  row_r[0];
    end

    // Pair-max of the held even pixel with the incoming odd pixel, then window max.
    always_comb begin
        pm_s   = '0;
        pool_s = '0;
        for (int c = 0; c < CH; c++) begin
            pm_s[c] = smax16(hold_r[c], in[c]);
`ifdef MAXPOOL_RELU_EN
            pool_s[c] = relu16(smax16(linebuf_r[lb_addr_s][c], pm_s[c]));
`else
            pool_s[c] = smax16(linebuf_r[lb_addr_s][c], pm_s[c]);
`endif
        end
    end

    // Raster position counters; they advance only on accepted pixels.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            col_r <= '0;
            row_r <= '0;
        end else if (vld_in) begin
            if (col_r == COL_LAST) begin
                col_r <= '0;
                if (row_r == ROW_LAST) begin
                    row_r <= '0;
                end else begin
                    row_r <= row_r + CW'(1);
                end
            end else begin
                col_r <= col_r + CW'(1);
                row_r <= row_r;
            end
        end else begin
            col_r <= col_r;
            row_r <= row_r;
        end
    end

    // Hold register captures each even-column pixel; it is fully rewritten before use.
    always_ff @(posedge clock) begin
        if (hold_wr_s) begin
            hold_r <= in;
        end else begin
            hold_r <= hold_r;
        end
    end

    // Line buffer stores even-row pair-maxima; every entry is written before it is read.
    always_ff @(posedge clock) begin
        if (lb_wr_s) begin
            linebuf_r[lb_addr_s] <= pm_s;
        end
    end

    // Registered output: one-cycle pulse per completed window, data held between pulses.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vld_out_r <= 1'b0;
            out_r     <= '0;
        end else if (emit_s) begin
            vld_out_r <= 1'b1;
            out_r     <= pool_s;
        end else begin
            vld_out_r <= 1'b0;
            out_r     <= out_r;
        end
    end

    assign vld_out = vld_out_r;
    assign out     = out_r;

endmodule

// File: tb/tb_maxpool_2x2.sv
// tb_maxpool_2x2: table-driven directed bench for maxpool_2x2 with IMG_SIZE=4, CH=2.
// Images are listed with hand-computed pooled results; a monitor checks every
// vld_out pulse against the expected value and cycle.
module tb_maxpool_2x2;

    localparam int IMG = 4;
    localparam int CH  = 2;

`ifdef MAXPOOL_RELU_EN
    localparam logic [15:0] NEG1_OUT = 16'h0000;
    localparam logic [15:0] MIN_OUT  = 16'h0000;
`else
    localparam logic [15:0] NEG1_OUT = 16'hFFFF;
    localparam logic [15:0] MIN_OUT  = 16'h8000;
`endif

    logic                clock  = 1'b0;
    logic                reset  = 1'b1;
    logic                vld_in = 1'b0;
    logic [CH-1:0][15:0] din    = '0;
    logic                vld_out;
    logic [CH-1:0][15:0] dout;

    maxpool_2x2 #(.IMG_SIZE(IMG), .CH(CH)) dut (
        .clock   (clock),
        .reset   (reset),
        .vld_in  (vld_in),
        .in      (din),
        .vld_out (vld_out),
        .out     (dout)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] px0 [16];
        logic [15:0] px1 [16];
        logic [15:0] ex0 [4];
        logic [15:0] ex1 [4];
    } vec_t;

    typedef struct {
        int          cyc;
        logic [15:0] e0;
        logic [15:0] e1;
    } exp_t;

    vec_t vecs [4];
    exp_t exp_q [$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   prow     = 0;
    int   pcol     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Fill one 2x2 window of one channel, positions p0..p3 in raster order.
    task automatic set_win(input int v, input int w, input int ch,
                           input logic [15:0] p0, input logic [15:0] p1,
                           input logic [15:0] p2, input logic [15:0] p3);
        logic [15:0] pv [4];
        pv = '{p0, p1, p2, p3};
        for (int p = 0; p < 4; p++) begin
            int r, c, idx;
            r   = (w / 2) * 2 + p / 2;
            c   = (w % 2) * 2 + p % 2;
            idx = r * IMG + c;
            if (ch == 0) vecs[v].px0[idx] = pv[p];
            else         vecs[v].px1[idx] = pv[p];
        end
    endtask

    task automatic send_pixel(input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] ea, input logic [15:0] eb);
        exp_t e;
        @(negedge clock);
        vld_in = 1'b1;
        din[0] = a;
        din[1] = b;
        if ((prow % 2 == 1) && (pcol % 2 == 1)) begin
            e.cyc = cyc + 1;
            e.e0  = ea;
            e.e1  = eb;
            exp_q.push_back(e);
        end
        if (pcol == IMG - 1) begin
            pcol = 0;
            prow = (prow == IMG - 1) ? 0 : prow + 1;
        end else begin
            pcol = pcol + 1;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clock);
            vld_in = 1'b0;
        end
    endtask

    task automatic send_pixels(input int v, input int npix, input bit bubbles);
        for (int idx = 0; idx < npix; idx++) begin
            int r, c, k;
            r = idx / IMG;
            c = idx % IMG;
            k = (r / 2) * 2 + c / 2;
            if (bubbles) begin
                while ($urandom_range(0, 1) == 1) idle(1);
            end
            send_pixel(vecs[v].px0[idx], vecs[v].px1[idx], vecs[v].ex0[k], vecs[v].ex1[k]);
        end
    endtask

    initial begin
        // Vector 0: ramp, 4r+c on both channels.
        // Vector 1: ramp + 100.
        for (int i = 0; i < 16; i++) begin
            vecs[0].px0[i] = 16'(i);
            vecs[0].px1[i] = 16'(i);
            vecs[1].px0[i] = 16'(i + 100);
            vecs[1].px1[i] = 16'(i + 100);
        end
        vecs[0].ex0 = '{16'd5, 16'd7, 16'd13, 16'd15};
        vecs[0].ex1 = '{16'd5, 16'd7, 16'd13, 16'd15};
        vecs[1].ex0 = '{16'd105, 16'd107, 16'd113, 16'd115};
        vecs[1].ex1 = '{16'd105, 16'd107, 16'd113, 16'd115};

        // Vector 2: all -100, one -1 per window at position w (ch0) / 3-w (ch1).
        for (int i = 0; i < 16; i++) begin
            vecs[2].px0[i] = 16'hFF9C;
            vecs[2].px1[i] = 16'hFF9C;
        end
        for (int w = 0; w < 4; w++) begin
            int r0, c0, r1, c1;
            r0 = (w / 2) * 2 + w / 2;
            c0 = (w % 2) * 2 + w % 2;
            r1 = (w / 2) * 2 + (3 - w) / 2;
            c1 = (w % 2) * 2 + (3 - w) % 2;
            vecs[2].px0[r0 * IMG + c0] = 16'hFFFF;
            vecs[2].px1[r1 * IMG + c1] = 16'hFFFF;
        end
        vecs[2].ex0 = '{NEG1_OUT, NEG1_OUT, NEG1_OUT, NEG1_OUT};
        vecs[2].ex1 = '{NEG1_OUT, NEG1_OUT, NEG1_OUT, NEG1_OUT};

        // Vector 3: signed extremes on ch0, bitwise complement on ch1.
        set_win(3, 0, 0, 16'h8000, 16'h7FFF, 16'h0000, 16'hFFFF);
        set_win(3, 1, 0, 16'h8000, 16'h8000, 16'h8000, 16'h8000);
        set_win(3, 2, 0, 16'h7FFE, 16'h7FFF, 16'h8001, 16'h0001);
        set_win(3, 3, 0, 16'hFFFE, 16'hFFFF, 16'h8000, 16'hFFFD);
        for (int i = 0; i < 16; i++) vecs[3].px1[i] = ~vecs[3].px0[i];
        vecs[3].ex0 = '{16'h7FFF, MIN_OUT, 16'h7FFF, NEG1_OUT};
        vecs[3].ex1 = '{16'h7FFF, 16'h7FFF, 16'h7FFE, 16'h7FFF};

        // Pulse monitor: every vld_out must match the head of the expected queue.
        fork
            forever begin
                @(negedge clock);
                if (!reset) begin
                    if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                        check("missed_pulse", 32'(cyc), 32'(exp_q[0].cyc));
                        void'(exp_q.pop_front());
                    end
                    if (vld_out) begin
                        if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
                            check("unexpected_pulse", {31'd0, vld_out}, 32'd0);
                        end else begin
                            check("pool_out", dout, {exp_q[0].e1, exp_q[0].e0});
                            void'(exp_q.pop_front());
                        end
                    end
                end
            end
        join_none

        // Reset state.
        @(negedge clock);
        check("reset_vld_out", {31'd0, vld_out}, 32'd0);
        check("reset_out", dout, 32'd0);
        reset = 1'b0;

        // Table: ramp, ramp+100 back-to-back, negatives, extremes, all gap-free.
        for (int v = 0; v < 4; v++) send_pixels(v, 16, 1'b0);
        idle(3);
        check("out_hold", dout, {vecs[3].ex1[3], vecs[3].ex0[3]});
        check("table_drained", 32'(exp_q.size()), 32'd0);

        // Bubbles: ramp with random idle cycles.
        send_pixels(0, 16, 1'b1);
        idle(3);
        check("bubble_drained", 32'(exp_q.size()), 32'd0);

        // Reset mid-image: six ramp pixels, then reset right after the sixth edge.
        send_pixels(0, 6, 1'b0);
        @(posedge clock);
        #1;
        reset  = 1'b1;
        vld_in = 1'b0;
        exp_q.delete();
        prow = 0;
        pcol = 0;
        repeat (2) begin
            @(negedge clock);
            check("midreset_vld_out", {31'd0, vld_out}, 32'd0);
            check("midreset_out", dout, 32'd0);
        end
        reset = 1'b0;
        send_pixels(0, 16, 1'b0);
        idle(4);
        check("post_reset_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
